cc_psr_unit: RTL

- Producer end of the NZP interface: generates and holds the SLC-3 condition codes that the branch-enable logic consumes, inside the Processor Status Register (PSR).
- Also holds the privilege bit and the 3-bit priority field.
- Keeps a small internal LIFO of saved PSRs for interrupt entry and RTI, so nested interrupts restore the correct NZP/priority/privilege.
- Sits beside the datapath bus; FSM drives the load/push/pop strobes.

---
 rtl/slc3_psr_pkg.sv | 37 +++
 rtl/psr_lifo.sv | 54 +++++
 rtl/cc_psr_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/slc3_psr_pkg.sv
// Shared PSR types, bit positions and condition-code helpers for cc_psr_unit.
// Optional same-cycle NZP forwarding is enabled in the top by defining CC_BYPASS_EN.
package slc3_psr_pkg;

   typedef struct packed {
      logic       priv;
      logic [2:0] pri;
      logic [2:0] nzp;
   } psr_t;

   localparam logic [2:0] CC_N = 3'b100;
   localparam logic [2:0] CC_Z = 3'b010;
   localparam logic [2:0] CC_P = 3'b001;

   localparam int PSR_PRIV   = 15;
   localparam int PSR_PRI_HI = 10;
   localparam int PSR_PRI_LO = 8;

   function automatic logic [2:0] nzp_of(input logic [15:0] word);
      logic n;
      logic z;
      n = word[15];
      z = (word == 16'h0000);
      return {n, z, ~n & ~z};
   endfunction

   // Any pattern that is not exactly one-hot collapses to Z so nzp stays legal.
   function automatic logic [2:0] cc_sanitize(input logic [2:0] cc);
      logic [2:0] res;
      case (cc)
         CC_N, CC_Z, CC_P: res = cc;
         default:          res = CC_Z;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/psr_lifo.sv
// Saved-PSR stack for interrupt entry / RTI; caller guarantees push and pop are
// only asserted when accepted (not full / not empty) and never together.
module psr_lifo
   import slc3_psr_pkg::*;
#(
   parameter int STACK_DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push_i,
   input  logic pop_i,
   input  psr_t wr_data_i,
   output psr_t top_o,
   output logic full_o,
   output logic empty_o
);

   localparam int OW = $clog2(STACK_DEPTH + 1);
   localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   psr_t          mem_q [STACK_DEPTH];
   logic [OW-1:0] occ_q;
   logic [OW-1:0] occ_d;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] top_idx;

   assign wr_idx  = AW'(occ_q);
   assign top_idx = AW'(occ_q - OW'(1));
   assign full_o  = (occ_q == OW'(STACK_DEPTH));
   assign empty_o = (occ_q == '0);
   assign top_o   = mem_q[top_idx];

   always_comb begin
      occ_d = occ_q;
      if (pop_i)
         occ_d = occ_q - OW'(1);
      else if (push_i)
         occ_d = occ_q + OW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         occ_q <= '0;
      else
         occ_q <= occ_d;
   end

   // Entry contents are don't-care after reset, so no reset on the storage.
   always_ff @(posedge clk) begin
      if (push_i)
         mem_q[wr_idx] <= wr_data_i;
   end

endmodule

// File: rtl/cc_psr_unit.sv
// SLC-3 PSR: NZP condition codes, privilege, priority and a saved-PSR stack.
// Define CC_BYPASS_EN to add the combinational nzp_fwd output.
module cc_psr_unit
   import slc3_psr_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int STACK_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              ld_cc,
   input  logic              ld_psr,
   input  logic              push,
   input  logic              pop,
   input  logic [2:0]        int_pri,
   input  logic              err_clr,
   output logic [2:0]        nzp,
   output logic [15:0]       psr,
   output logic              stack_full,
   output logic              stack_empty,
   output logic              ovf_err,
   output logic              udf_err
`ifdef CC_BYPASS_EN
   ,
   output logic [2:0]        nzp_fwd
`endif
);

   psr_t        psr_q;
   psr_t        psr_d;
   psr_t        lifo_top;
   logic        ovf_q;
   logic        ovf_d;
   logic        udf_q;
   logic        udf_d;
   logic        lifo_push;
   logic        lifo_pop;
   logic        lifo_full;
   logic        lifo_empty;
   logic [15:0] cc_word;

   // Reduce the bus to a 16-bit word with the same sign and zero-ness.
   assign cc_word = {bus_in[DATA_W-1], 14'b0, |bus_in};

   psr_lifo #(.STACK_DEPTH(STACK_DEPTH)) u_lifo (
      .clk       (clk),
      .rst_n     (reset),
      .push_i    (lifo_push),
      .pop_i     (lifo_pop),
      .wr_data_i (psr_q),
      .top_o     (lifo_top),
      .full_o    (lifo_full),
      .empty_o   (lifo_empty)
   );

   always_comb begin
      psr_d     = psr_q;
      ovf_d     = ovf_q & ~err_clr;
      udf_d     = udf_q & ~err_clr;
      lifo_push = 1'b0;
      lifo_pop  = 1'b0;
      if (pop) begin
         if (lifo_empty) begin
            udf_d = 1'b1;
         end else begin
            lifo_pop = 1'b1;
            psr_d    = lifo_top;
         end
      end else if (push) begin
         if (lifo_full) begin
            ovf_d = 1'b1;
         end else begin
            lifo_push = 1'b1;
            psr_d.priv = 1'b0;
            psr_d.pri  = int_pri;
         end
      end else if (ld_psr) begin
         psr_d.priv = bus_in[PSR_PRIV];
         psr_d.pri  = bus_in[PSR_PRI_HI:PSR_PRI_LO];
         psr_d.nzp  = cc_sanitize(bus_in[2:0]);
      end else if (ld_cc) begin
         psr_d.nzp = nzp_of(cc_word);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         psr_q <= '{priv: 1'b0, pri: 3'b000, nzp: CC_Z};
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         psr_q <= psr_d;
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign nzp         = psr_q.nzp;
   assign psr         = {psr_q.priv, 4'b0, psr_q.pri, 5'b0, psr_q.nzp};
   assign stack_full  = lifo_full;
   assign stack_empty = lifo_empty;
   assign ovf_err     = ovf_q;
   assign udf_err     = udf_q;

`ifdef CC_BYPASS_EN
   assign nzp_fwd = psr_d.nzp;
`endif

endmodule
